host_output_drain: RTL
======================

Name: host_output_drain

Overview:
- FPGA-side receiver for the emulator's decoupled output stream (io_o valid/ready/bits).
- Buffers output words in a small FIFO and presents the head word to a host-polled wire-out register set.
- Host pops one word per toggle of a wire-in bit, and confirms each pop by watching a sequence bit flip.
- Replaces the direct level wiring of io_o_ready, so one host write can never consume zero or several words.
- Sits between the emulator top and the okWireIn/okWireOut endpoints.
- Single clock domain; any CDC is handled outside this block.

Parameters:
- DATA_W, 16, width of each output word.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- io_o_valid  in  1  emulator output word valid.
- io_o_ready  out  1  block can accept a word.
- io_o_bits  in  DATA_W  emulator output word.
- host_pop_tog  in  1  wire-in bit; each change of value requests one pop.
- out_valid  out  1  FIFO non-empty; out_bits holds the head word.
- out_bits  out  DATA_W  head word; 0 when empty.
- out_seq  out  1  flips on every successful pop.
- level  out  $clog2(DEPTH)+1  current occupancy.
- pop_count  out  CNT_W  successful pops; wraps modulo 2^CNT_W.
- underflow_count  out  CNT_W  pop requests made while empty; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high):
  - rd_ptr, wr_ptr, level, out_seq, pop_count and underflow_count go to 0.
  - pop_tog_q loads host_pop_tog, so a toggle left at 1 by the host never causes a spurious pop after reset.
  - Reset mid-operation flushes all buffered data.
  - Resulting outputs: io_o_ready=1, out_valid=0, out_bits=0.
- Enqueue:
  - io_o_ready = (level != DEPTH); combinational from registered state only, with no dependence on io_o_valid.
  - Enqueue when io_o_valid && io_o_ready: write mem[wr_ptr], wr_ptr++ (wraps modulo DEPTH).
- Pop detect:
  - pop_req = host_pop_tog ^ pop_tog_q.
  - pop_tog_q <= host_pop_tog every non-reset cycle.
  - Only the value change counts; the level itself means nothing.
- Pop, when pop_req && level != 0:
  - rd_ptr++, out_seq flips, pop_count++.
- Pop request while empty (pop_req && level == 0):
  - No pointer change, out_seq unchanged, underflow_count increments (saturating).
- Latency:
  - Word enqueued in cycle N appears on out_valid/out_bits in cycle N+1.
  - Pop request sampled in cycle N takes effect (new head, out_seq flip) in cycle N+1.
- Head presentation:
  - out_bits = mem[rd_ptr] when level != 0, else 0.
  - out_valid = (level != 0).
- Simultaneous events:
  - Enqueue and pop in the same cycle: level unchanged, both pointers advance.
  - Enqueue into an empty FIFO with a pop in the same cycle: the pop is an underflow, because the word is not yet visible; the word remains in the FIFO.
  - When full, no enqueue occurs (ready low). A pop that cycle drops level to DEPTH-1, and ready rises the next cycle.
- Pointers: $clog2(DEPTH) bits each, wrapping. level carries the extra bit needed to tell full from empty.
- Host protocol:
  - Read {out_valid, out_seq, out_bits} together.
  - If valid, consume the word and toggle host_pop_tog.
  - Poll until out_seq flips before trusting the next word.

Test Plan:
- Reset with host_pop_tog=1, hold 5 cycles after release with no toggle -> io_o_ready=1, out_valid=0, out_seq=0, level=0, pop_count=0, underflow_count=0.
- Enqueue 0x1234 in cycle N -> cycle N+1: out_valid=1, out_bits=0x1234, level=1. Toggle host_pop_tog -> next cycle: out_valid=0, out_bits=0, out_seq=1, pop_count=1.
- Enqueue 0xA000..0xA004 back-to-back with io_o_valid held high -> first 4 accepted, io_o_ready=0 with level=4, 0xA004 held off. After one pop: out_bits=0xA001 and 0xA004 is accepted the following cycle. Drain all -> words in order 0xA000..0xA004, pop_count=5.
- Toggle host_pop_tog 3 times while empty -> underflow_count=3, out_seq unchanged. Preset underflow_count to all-ones and toggle again -> counter stays all-ones.
- With level=2, enqueue and pop in the same cycle -> level stays 2, head advances. With level=0, enqueue and pop together -> underflow_count+1, level=1, out_bits equals the enqueued word.
- Fill to 3 entries, assert reset for 1 cycle mid-stream -> level=0, out_valid=0, out_seq=0, io_o_ready=1. A later fresh enqueue/pop cycle works normally.

Source files
------------

// File: rtl/host_output_drain.sv
// -----------------------------------------------------------------------------
// host_output_drain
//
// Receives the emulator's decoupled output stream (io_o valid/ready/bits).
// Words are buffered in a small FIFO. The head word is shown on a set of
// host-polled wire-out registers. The host pops one word for each change of
// value on the host_pop_tog wire-in bit. It confirms each pop by watching
// out_seq flip. One host write therefore consumes exactly one word, or
// counts as an underflow when the FIFO is empty.
//
// Single clock domain. Any CDC is handled outside this block.
// DEPTH must be a power of two and at least 2.
//
// Ports:
//   clock           block clock
//   reset           synchronous, active-high reset
//   io_o_valid      emulator output word valid
//   io_o_ready      block can accept a word (depends on registered state only)
//   io_o_bits       emulator output word
//   host_pop_tog    wire-in bit; each change of value requests one pop
//   out_valid       FIFO non-empty; out_bits holds the head word
//   out_bits        head word; 0 when empty
//   out_seq         flips on every successful pop
//   level           current occupancy (extra bit separates full from empty)
//   pop_count       successful pops, wraps
//   underflow_count pop requests made while empty, saturates at all-ones
// -----------------------------------------------------------------------------
module host_output_drain #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_o_valid,
    output logic                     io_o_ready,
    input  logic [DATA_W-1:0]        io_o_bits,
    input  logic                     host_pop_tog,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_bits,
    output logic                     out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         pop_count,
    output logic [CNT_W-1:0]         underflow_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Storage and registered state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              pop_tog_q;
    logic              out_seq_q, out_seq_d;
    logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]  unf_cnt_q, unf_cnt_d;

    // Per-cycle events
    logic full;
    logic empty;
    logic pop_req;
    logic enq;
    logic deq;
    logic unf;

    // Event decode. Full and empty come from level_q only, so ready never
    // depends on io_o_valid. A pop decision uses the pre-enqueue level.
    // This means a word written this cycle cannot satisfy a pop made in
    // the same cycle.
    always_comb begin
        full    = (level_q == FULL_LVL);
        empty   = (level_q == '0);
        pop_req = host_pop_tog ^ pop_tog_q;
        enq     = io_o_valid && !full;
        deq     = pop_req && !empty;
        unf     = pop_req && empty;
    end

    // Next-state computation
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        out_seq_d = out_seq_q;
        pop_cnt_d = pop_cnt_q;
        unf_cnt_d = unf_cnt_q;

        // DEPTH is a power of two, so pointer overflow is the wrap.
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (deq) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            out_seq_d = ~out_seq_q;
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
        end

        if (unf && (unf_cnt_q != '1)) begin
            unf_cnt_d = unf_cnt_q + CNT_W'(1);
        end

        unique case ({enq, deq})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers. On reset, pop_tog_q takes the live toggle value.
    // A toggle the host left at 1 therefore does not look like a request
    // once reset is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            pop_tog_q <= host_pop_tog;
            out_seq_q <= 1'b0;
            pop_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            pop_tog_q <= host_pop_tog;
            out_seq_q <= out_seq_d;
            pop_cnt_q <= pop_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    // FIFO storage needs no reset. Stale contents are hidden by level_q.
    always_ff @(posedge clock) begin
        if (!reset && enq) begin
            mem_q[wr_ptr_q] <= io_o_bits;
        end
    end

    // Outputs
    always_comb begin
        io_o_ready      = !full;
        out_valid       = !empty;
        out_bits        = empty ? '0 : mem_q[rd_ptr_q];
        out_seq         = out_seq_q;
        level           = level_q;
        pop_count       = pop_cnt_q;
        underflow_count = unf_cnt_q;
    end

endmodule
